// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO draining into a UART transmitter, 8N1 by default
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit between data and stop).
module uart_tx_fifo #(
    parameter int CLK_HZ     = 1000000,
    parameter int BAUD       = 9600,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_en,
    input  logic [7:0] in,
    output logic       tx,
    output logic       busy,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int DEPTH        = 1 << DEPTH_LOG2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0]   COUNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              bit_idx_q, bit_idx_d;
    logic [7:0]              shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic [7:0]              mem [DEPTH];
`ifdef UART_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    logic empty_w, full_w, pop, push, bit_done;
    logic [7:0] head;

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == COUNT_MAX);
    assign head     = mem[rd_ptr_q];
    assign bit_done = (cnt_q == CNT_LAST);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign pop      = (state_q == S_IDLE) && !empty_w;
    assign push     = in_en && (!full_w || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        if (in_en && !push) overflow_d = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty_w) begin
                    state_d   = S_START;
                    shift_d   = head;
                    bit_idx_d = 3'd0;
                    cnt_d     = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^head;
`endif
                end
            end
            S_START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line outputs follow the current state one cycle late so tx is glitch-free.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_q != S_IDLE);
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign empty    = empty_w;
    assign full     = full_w;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo at 10 clocks per bit
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int CPB         = 10;
    localparam int FRAME_CLKS  = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_en;
    logic [7:0] din;
    logic       tx, busy, empty, full, overflow;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_fifo #(
        .CLK_HZ     (1000000),
        .BAUD       (100000),
        .DEPTH_LOG2 (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_en    (in_en),
        .in       (din),
        .tx       (tx),
        .busy     (busy),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bit j: start, d0..d7, [even parity], stop.
    function automatic logic exp_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called on the negedge of frame cycle k0; returns on the gap cycle after the frame.
    task automatic check_frame(input logic [7:0] d, input int k0);
        for (int k = k0; k < FRAME_CLKS; k++) begin
            check($sformatf("frame%02h_tx_c%0d", d, k), tx, exp_bit(d, k / CPB));
            check($sformatf("frame%02h_busy_c%0d", d, k), busy, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic check_gap(input string tag);
        check({tag, "_gap_tx"}, tx, 1'b1);
        check({tag, "_gap_busy"}, busy, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        logic saw_low;
        rst   = 1'b1;
        in_en = 1'b0;
        din   = 8'h00;

        // 1. reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);

        // 2. single byte 0xA5, exact latency and bit timing
        in_en = 1'b1; din = 8'hA5;
        @(negedge clk);
        in_en = 1'b0;
        check("a5_e0_tx", tx, 1'b1);
        check("a5_e0_empty", empty, 1'b0);
        @(negedge clk);
        check("a5_e1_tx", tx, 1'b1);
        check("a5_e1_busy", busy, 1'b0);
        check("a5_e1_empty", empty, 1'b1);
        @(negedge clk);
        check_frame(8'hA5, 0);
        check("a5_end_empty", empty, 1'b1);
        check_gap("a5");

        // 3. five back-to-back writes fill the FIFO exactly
        in_en = 1'b1; din = 8'h01;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            din = 8'(i);
        end
        @(negedge clk);
        in_en = 1'b0;
        check("fill_full", full, 1'b1);
        check("fill_overflow", overflow, 1'b0);
        check("fill_empty", empty, 1'b0);
        check_frame(8'h01, 2);
        for (int i = 2; i <= 5; i++) begin
            check_gap($sformatf("fill%0d", i));
            check_frame(8'(i), 0);
        end
        check("fill_end_empty", empty, 1'b1);
        check_gap("fill_end");

        // 4. six writes: sixth dropped, overflow sticky
        in_en = 1'b1; din = 8'h10;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            din = 8'h10 + 8'(i);
        end
        @(negedge clk);
        in_en = 1'b0;
        check("ovf_set", overflow, 1'b1);
        check("ovf_full", full, 1'b1);
        check_frame(8'h10, 3);
        for (int i = 1; i <= 4; i++) begin
            check_gap($sformatf("ovf%0d", i));
            check_frame(8'h10 + 8'(i), 0);
        end
        check("ovf_end_empty", empty, 1'b1);
        saw_low = 1'b0;
        repeat (2 * FRAME_CLKS) begin
            if (tx !== 1'b1) saw_low = 1'b1;
            @(negedge clk);
        end
        check("ovf_no_sixth_frame", saw_low, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        // 5. reset during data bit 3 of 0x3C with two bytes queued
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_overflow", overflow, 1'b0);
        in_en = 1'b1; din = 8'h3C;
        @(negedge clk);
        din = 8'h11;
        @(negedge clk);
        din = 8'h22;
        @(negedge clk);
        in_en = 1'b0;
        check("abort_start_tx", tx, 1'b0);
        repeat (45) @(negedge clk);
        check("abort_bit3_tx", tx, 1'b1);
        check("abort_queued", empty, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_empty", empty, 1'b1);
        saw_low = 1'b0;
        repeat (2 * FRAME_CLKS) begin
            if (tx !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
            @(negedge clk);
        end
        check("abort_no_frames", saw_low, 1'b0);

`ifdef UART_TX_PARITY_EN
        // 6. even parity: 0x07 -> 1, 0x03 -> 0
        in_en = 1'b1; din = 8'h07;
        @(negedge clk);
        in_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        repeat (95) @(negedge clk);
        check("par07_bit", tx, 1'b1);
        repeat (10) @(negedge clk);
        check("par07_stop_busy", busy, 1'b1);
        repeat (5) @(negedge clk);
        check("par07_len_busy", busy, 1'b0);
        in_en = 1'b1; din = 8'h03;
        @(negedge clk);
        in_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_frame(8'h03, 0);
        check("par03_bit_const", exp_bit(8'h03, 9), 1'b0);
        check_gap("par03");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
